// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline: halt FSM states, the E-stage control word,
// its bubble value and the valid-qualification helper.
package riscv_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } halt_state_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [1:0] alu_src;
    logic [3:0] alu_control;
    logic [2:0] funct3;
    logic       ecall;
    logic       ebreak;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_NOP = '0;

  // Side-effecting bits of an invalid D-stage slot must never reach E.
  function automatic ctrl_e_t qualify_ctrl(ctrl_e_t c);
    ctrl_e_t q;
    q           = c;
    q.reg_write = c.reg_write & c.valid;
    q.mem_write = c.mem_write & c.valid;
    q.jump      = c.jump & c.valid;
    q.branch    = c.branch & c.valid;
    q.ecall     = c.ecall & c.valid;
    q.ebreak    = c.ebreak & c.valid;
    return q;
  endfunction

endpackage

// File: rtl/id_ex_halt_fsm.sv
// ECALL/EBREAK drain-and-halt controller. Once a trap is captured into E it counts
// DRAIN_CYCLES unstalled edges so the trap can retire through M and W, then halts
// until reset.
module id_ex_halt_fsm
  import riscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,   // trap instruction loaded into E this edge
  input  logic advance,   // edge is not stalled
  output logic halt_req,
  output logic halted
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(DRAIN_CYCLES - 1);

  if (DRAIN_CYCLES < 1) begin : gen_bad_drain
    $error("id_ex_halt_fsm: DRAIN_CYCLES must be at least 1");
  end

  halt_state_t     state;
  logic [CntW-1:0] cnt;

  // State, drain counter and registered Halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (capture) begin
            state <= DRAIN;
            cnt   <= CntInit;
          end
        end
        DRAIN: begin
          if (advance) begin
            if (cnt == '0) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        HALT: halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  // Front end stays frozen from the moment the trap is in E.
  always_comb begin
    halt_req = (state == DRAIN) || (state == HALT);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush/bubble, valid bit and trap drain-and-halt.
// Optional feature macro: ID_EX_PERF_CNT_EN adds IssueCnt/BubbleCnt counters.
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic [1:0]           ResultSrcD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic [1:0]           ALUSrcD,
  input  logic [3:0]           ALUControlD,
  input  logic [2:0]           funct3D,
  input  logic                 EcallD,
  input  logic                 EbreakD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] RdD,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic [1:0]           ALUSrcE,
  output logic [3:0]           ALUControlE,
  output logic [2:0]           funct3E,
  output logic                 EcallE,
  output logic                 EbreakE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [REG_IDX_W-1:0] Rs1E,
  output logic [REG_IDX_W-1:0] Rs2E,
  output logic [REG_IDX_W-1:0] RdE,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]          IssueCnt,
  output logic [31:0]          BubbleCnt,
`endif
  output logic                 HaltReq,
  output logic                 Halted
);

  typedef struct packed {
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      imm_ext;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
  } data_e_t;

  ctrl_e_t ctrl_raw, ctrl_d, ctrl_q;
  data_e_t data_d, data_q;
  logic    bubble;
  logic    trap_capture;

  // Gather D-stage fields into the E-stage word, qualifying control by ValidD.
  always_comb begin
    ctrl_raw             = CTRL_NOP;
    ctrl_raw.valid       = ValidD;
    ctrl_raw.reg_write   = RegWriteD;
    ctrl_raw.result_src  = ResultSrcD;
    ctrl_raw.mem_write   = MemWriteD;
    ctrl_raw.jump        = JumpD;
    ctrl_raw.branch      = BranchD;
    ctrl_raw.alu_src     = ALUSrcD;
    ctrl_raw.alu_control = ALUControlD;
    ctrl_raw.funct3      = funct3D;
    ctrl_raw.ecall       = EcallD;
    ctrl_raw.ebreak      = EbreakD;
    ctrl_d               = qualify_ctrl(ctrl_raw);
    data_d = '{rd1: RD1D, rd2: RD2D, pc: PCD, pc_plus4: PCPlus4D, imm_ext: ImmExtD,
               rs1: Rs1D, rs2: Rs2D, rd: RdD};
  end

  // Once halted, E is held at a bubble regardless of what the hazard unit asks.
  always_comb begin
    bubble       = FlushE | Halted;
    trap_capture = !bubble && !StallE && ValidD && (EcallD || EbreakD);
  end

  // E-stage register bank: reset > bubble > stall > load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
      data_q <= '0;
    end else if (bubble) begin
      ctrl_q <= CTRL_NOP;
      data_q <= '0;
    end else if (!StallE) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  id_ex_halt_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (trap_capture),
    .advance (!StallE),
    .halt_req(HaltReq),
    .halted  (Halted)
  );

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] issue_cnt_q, bubble_cnt_q;

  // Count what each edge loads into E; stalled edges load nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (bubble) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else if (!StallE) begin
      if (ValidD) issue_cnt_q <= issue_cnt_q + 32'd1;
      else        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign IssueCnt  = issue_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`endif

  assign ValidE      = ctrl_q.valid;
  assign RegWriteE   = ctrl_q.reg_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign funct3E     = ctrl_q.funct3;
  assign EcallE      = ctrl_q.ecall;
  assign EbreakE     = ctrl_q.ebreak;
  assign RD1E        = data_q.rd1;
  assign RD2E        = data_q.rd2;
  assign PCE         = data_q.pc;
  assign PCPlus4E    = data_q.pc_plus4;
  assign ImmExtE     = data_q.imm_ext;
  assign Rs1E        = data_q.rs1;
  assign Rs2E        = data_q.rs2;
  assign RdE         = data_q.rd;

endmodule
